// File: rtl/btn_step_conditioner.sv
// Button/direction input conditioner: 2-flop synchronisers, counting debouncers,
// and a press/auto-repeat FSM producing single-cycle step pulses for the counter.
module btn_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_raw,
  input  logic dir_raw,
  output logic step,
  output logic dir,
  output logic pressed,
  output logic repeating
);

  // state  | meaning
  // IDLE   | waiting for a fresh debounced press with ena high
  // DELAY  | first step issued, counting down to the first auto-repeat
  // REPEAT | button held, issuing a step every REPEAT_RATE cycles
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  localparam int DTW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RTW  = $clog2(RMAX + 1);
  localparam logic [DTW-1:0] DB_LAST    = DTW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RTW-1:0] DELAY_LAST = RTW'(REPEAT_DELAY - 1);
  localparam logic [RTW-1:0] RATE_LAST  = RTW'(REPEAT_RATE - 1);

  // channel 0 = button, channel 1 = direction
  logic [1:0]     sync1, sync2, stable, flip;
  logic [DTW-1:0] db_timer [2];
  logic           btn_rise, btn_fall;

  state_t         state_q, state_d;
  logic [RTW-1:0] rtimer_q, rtimer_d;
  logic           step_q, step_d;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      flip[i] = (sync2[i] != stable[i]) && (db_timer[i] == DB_LAST);
    end
  end

  // Edges are taken from the flip about to happen so step lines up with pressed.
  assign btn_rise = flip[0] &&  sync2[0];
  assign btn_fall = flip[0] && !sync2[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < 2; i++) db_timer[i] <= '0;
    end else begin
      sync1 <= {dir_raw, btn_raw};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          db_timer[i] <= '0;
        end else if (flip[i]) begin
          stable[i]   <= sync2[i];
          db_timer[i] <= '0;
        end else begin
          db_timer[i] <= db_timer[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rtimer_q <= '0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rtimer_q <= rtimer_d;
      step_q   <= step_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rtimer_d = rtimer_q;
    step_d   = 1'b0;
    // Release or disable wins over any coincident step.
    if (btn_fall || !ena) begin
      state_d  = IDLE;
      rtimer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_rise) begin
            step_d   = 1'b1;
            rtimer_d = '0;
            state_d  = DELAY;
          end
        end
        DELAY: begin
          if (rtimer_q == DELAY_LAST) begin
            step_d   = 1'b1;
            rtimer_d = '0;
            state_d  = REPEAT;
          end else begin
            rtimer_d = rtimer_q + 1'b1;
          end
        end
        REPEAT: begin
          if (rtimer_q == RATE_LAST) begin
            step_d   = 1'b1;
            rtimer_d = '0;
          end else begin
            rtimer_d = rtimer_q + 1'b1;
          end
        end
        default: begin
          state_d  = IDLE;
          rtimer_d = '0;
        end
      endcase
    end
  end

  assign step      = step_q;
  assign pressed   = stable[0];
  assign dir       = stable[1];
  assign repeating = (state_q == REPEAT);

endmodule

// File: doc/btn_step_conditioner.md
Name: btn_step_conditioner

Overview:
Input conditioning stage directly upstream of the 4-bit up/down counter. It synchronises and debounces a raw push-button and a raw direction switch. It emits single-cycle step pulses (one per press, plus auto-repeat while held) and a clean direction level, which drive the counter's count-enable and select inputs. It runs in the system clock domain, so the counter no longer needs to be clocked from a pad.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive mismatching cycles required before a debounced level flips (>=1)
REPEAT_DELAY, 64, cycles from first step to first auto-repeat step (>=2)
REPEAT_RATE, 16, cycles between auto-repeat steps (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
ena  input  1  design enable; low suppresses steps
btn_raw  input  1  asynchronous, bouncy push-button
dir_raw  input  1  asynchronous, bouncy direction switch (1=up)
step  output  1  registered single-cycle count-enable pulse
dir  output  1  registered debounced direction level
pressed  output  1  registered debounced button level
repeating  output  1  high while FSM is in REPEAT

Behaviour:
- Reset: rst_n is synchronous and active-low. With rst_n=0 at a clock edge, all sync flops, debounced levels, timers and outputs go to 0, and the FSM goes to IDLE. Reset overrides all other activity, including mid-repeat.
- Synchroniser: each raw input passes through a 2-flop synchroniser (sync1, sync2).
- Debounce (per input, independent): timer width is $clog2(DEBOUNCE_CYCLES+1).
  - If sync2 == stable: timer <= 0.
  - Otherwise the timer increments.
  - When the timer == DEBOUNCE_CYCLES-1 with mismatch: stable <= sync2 and timer <= 0.
- Latency: raw change sampled into sync1 at edge 0 → stable and pressed/dir update at edge DEBOUNCE_CYCLES+1. Any glitch shorter than DEBOUNCE_CYCLES cycles is fully rejected.
- dir = debounced dir_raw, always tracked, independent of ena and FSM.
- pressed = debounced btn_raw, always tracked, independent of ena.
- FSM states: IDLE, DELAY, REPEAT. The repeat timer is sized for max(REPEAT_DELAY, REPEAT_RATE).
  - IDLE: on the debounced button rising edge with ena=1 → step <= 1, timer <= 0, go to DELAY.
  - DELAY: timer increments. At timer == REPEAT_DELAY-1 → step <= 1, timer <= 0, go to REPEAT.
  - REPEAT: timer increments. At timer == REPEAT_RATE-1 → step <= 1, timer <= 0, stay in REPEAT.
  - Any state: debounced button falling edge or ena=0 → IDLE, timer <= 0, step <= 0. Release/ena-low wins over a coincident step.
- step is high for exactly one cycle per event; it is never high on two consecutive cycles unless REPEAT_RATE=1.
- repeating is registered and high exactly while the state is REPEAT.
- ena handling:
  - ena rising while the button is already held does not generate a step. A fresh debounced rising edge is required.
  - Debouncers keep running while ena=0.
- Direction change during DELAY/REPEAT takes effect on the next step; the FSM does not restart.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3.
1. Clean press: btn_raw 0→1 before edge 0, held → pressed and step rise at edge 5. step is high for 1 cycle. Further steps at edges 13, 16, 19. repeating=1 from edge 13.
2. Bounce rejection: btn_raw toggles every 2 cycles for 20 cycles, then returns to 0 → step, pressed and repeating stay 0 throughout.
3. Release: after scenario 1, btn_raw 1→0 at edge 20 → pressed falls at edge 25. No step after edge 22. FSM is in IDLE and repeating=0.
4. Direction: dir_raw 0→1 pulse of 3 cycles → dir stays 0. A held change → dir=1 at change+5. Up/down steps continue uninterrupted during REPEAT.
5. ena gating: hold the button with ena=0, then raise ena → no step. Release and re-press → step at press edge +5.
6. Reset mid-repeat: rst_n=0 for 1 cycle during REPEAT → next cycle has all outputs 0 and FSM in IDLE. With btn_raw still high, pressed re-asserts at edge +6 after reset release, together with one step.
